program_counter_stack: RTL and testbench

//   Parametrised successor to the CPU program counter. Holds the fetch

---
 rtl/program_counter_stack_if.sv | 34 +++
 rtl/program_counter_stack.sv | 102 ++++++++++
 tb/tb_program_counter_stack.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/program_counter_stack_if.sv
// Control/bus bundle for program_counter_stack.
//   master : control block side (drives command strobes and jump target)
//   slave  : program counter side (drives PC, bus, stack status and error flags)
interface program_counter_stack_if #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned STACK_DEPTH = 4
);
  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic                  inc;
  logic                  load;
  logic                  call;
  logic                  ret;
  logic                  out_en;
  logic                  clear_err;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic [ADDR_WIDTH-1:0] bus_out;
  logic [DEPTH_W-1:0]    depth;
  logic                  stack_full;
  logic                  stack_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output inc, load, call, ret, out_en, clear_err, addr_in,
    input  pc_out, bus_out, depth, stack_full, stack_empty, overflow, underflow
  );

  modport slave (
    input  inc, load, call, ret, out_en, clear_err, addr_in,
    output pc_out, bus_out, depth, stack_full, stack_empty, overflow, underflow
  );
endinterface

// File: rtl/program_counter_stack.sv
// Program counter with hardware return-address stack.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of program_counter_stack_if
//                inputs  inc/load/call/ret/out_en/clear_err/addr_in
//                outputs pc_out (registered), bus_out (pc_out gated by out_en),
//                        depth, stack_full, stack_empty, sticky overflow/underflow
// Commands are mutually prioritised ret > call > load > inc, one per cycle.
module program_counter_stack #(
  parameter int unsigned           ADDR_WIDTH   = 4,
  parameter int unsigned           STACK_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  program_counter_stack_if.slave bus
);

  localparam int unsigned    DW        = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0]  DEPTH_MAX = DW'(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]         depth_q, depth_d;
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0] stack_d [STACK_DEPTH];
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] top;
  logic                  full;
  logic                  empty;

  assign pc_inc = pc_q + ADDR_WIDTH'(1);
  assign full   = (depth_q == DEPTH_MAX);
  assign empty  = (depth_q == '0);

  // Current top of stack (entry depth-1); don't-care when empty.
  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) top = stack_q[i];
    end
  end

  // Next-state: prioritised command decode; error set wins over clear.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    stack_d = stack_q;
    ovf_d   = bus.clear_err ? 1'b0 : ovf_q;
    unf_d   = bus.clear_err ? 1'b0 : unf_q;

    if (bus.ret) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        pc_d    = top;
        depth_d = depth_q - DW'(1);
      end
    end else if (bus.call) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
          if (depth_q == DW'(i)) stack_d[i] = pc_inc;
        end
        depth_d = depth_q + DW'(1);
        pc_d    = bus.addr_in;
      end
    end else if (bus.load) begin
      pc_d = bus.addr_in;
    end else if (bus.inc) begin
      pc_d = pc_inc;
    end
  end

  // State registers; reset discards stack content immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      depth_q <= '0;
      stack_q <= '{default: '0};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      stack_q <= stack_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.bus_out     = bus.out_en ? pc_q : '0;
  assign bus.depth       = depth_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;

endmodule

// File: tb/tb_program_counter_stack.sv
module tb_program_counter_stack;

  localparam int unsigned AW = 4;
  localparam int unsigned SD = 4;

  logic clk;
  logic rst_n;

  program_counter_stack_if #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) bus ();

  program_counter_stack #(
    .ADDR_WIDTH  (AW),
    .STACK_DEPTH (SD),
    .RESET_VECTOR(4'h0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [AW-1:0] pc;
    int            depth;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Compare all observable outputs against one expected record.
  task automatic compare(input string tag, input exp_t e);
    logic [AW-1:0] eb;
    eb = bus.out_en ? e.pc : '0;
    check({tag, ".pc"},    8'(bus.pc_out),      8'(e.pc));
    check({tag, ".depth"}, 8'(bus.depth),       8'(e.depth));
    check({tag, ".full"},  8'(bus.stack_full),  8'(e.depth == SD));
    check({tag, ".empty"}, 8'(bus.stack_empty), 8'(e.depth == 0));
    check({tag, ".ovf"},   8'(bus.overflow),    8'(e.ovf));
    check({tag, ".unf"},   8'(bus.underflow),   8'(e.unf));
    check({tag, ".bus"},   8'(bus.bus_out),     8'(eb));
  endtask

  // Drive one command, push its expected result, clock it, pop and compare.
  task automatic step(input string tag,
                      input logic r, input logic c, input logic l, input logic i,
                      input logic ce, input logic [AW-1:0] a,
                      input logic [AW-1:0] epc, input int ed,
                      input logic eov, input logic eun);
    exp_t e;
    bus.ret = r; bus.call = c; bus.load = l; bus.inc = i;
    bus.clear_err = ce; bus.addr_in = a;
    e.pc = epc; e.depth = ed; e.ovf = eov; e.unf = eun;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.ret = 0; bus.call = 0; bus.load = 0; bus.inc = 0; bus.clear_err = 0;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      compare(tag, sb.pop_front());
    end
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    bus.inc = 0; bus.load = 0; bus.call = 0; bus.ret = 0;
    bus.out_en = 1; bus.clear_err = 0; bus.addr_in = '0;
    #12;
    e.pc = 4'h0; e.depth = 0; e.ovf = 0; e.unf = 0;
    compare("reset", e);
    @(negedge clk);
    rst_n = 1'b1;

    // Increment through full range and wrap
    for (int k = 0; k < 16; k++) step("inc", 0,0,0,1,0, 4'h0, 4'(k + 1), 0, 0, 0);

    // Simple call/return
    step("load3", 0,0,1,0,0, 4'h3, 4'h3, 0, 0, 0);
    step("call9", 0,1,0,0,0, 4'h9, 4'h9, 1, 0, 0);
    step("ret4",  1,0,0,0,0, 4'h0, 4'h4, 0, 0, 0);

    // Nested calls to full, overflow, unwind
    step("load1", 0,0,1,0,0, 4'h1, 4'h1, 0, 0, 0);
    step("callA", 0,1,0,0,0, 4'hA, 4'hA, 1, 0, 0);
    step("callB", 0,1,0,0,0, 4'hB, 4'hB, 2, 0, 0);
    step("callC", 0,1,0,0,0, 4'hC, 4'hC, 3, 0, 0);
    step("callD", 0,1,0,0,0, 4'hD, 4'hD, 4, 0, 0);
    step("ovf",   0,1,0,0,0, 4'h5, 4'hD, 4, 1, 0);
    step("ovf_ce",0,1,0,0,1, 4'h5, 4'hD, 4, 1, 0);
    step("retD",  1,0,0,0,0, 4'h0, 4'hD, 3, 1, 0);
    step("retC",  1,0,0,0,0, 4'h0, 4'hC, 2, 1, 0);
    step("retB",  1,0,0,0,0, 4'h0, 4'hB, 1, 1, 0);
    step("ret2",  1,0,0,0,0, 4'h0, 4'h2, 0, 1, 0);
    step("clr_o", 0,0,0,0,1, 4'h0, 4'h2, 0, 0, 0);

    // Underflow and clear priority
    step("unf",    1,0,0,0,0, 4'h0, 4'h2, 0, 0, 1);
    step("unf_ce", 1,0,0,0,1, 4'h0, 4'h2, 0, 0, 1);
    step("clr_u",  0,0,0,0,1, 4'h0, 4'h2, 0, 0, 0);

    // Command priority and push of wrapped return address
    step("call7",  0,1,0,0,0, 4'h7, 4'h7, 1, 0, 0);
    step("prio_r", 1,1,1,1,0, 4'h9, 4'h3, 0, 0, 0);
    step("prio_c", 0,1,0,1,0, 4'h5, 4'h5, 1, 0, 0);
    step("ret_p",  1,0,0,0,0, 4'h0, 4'h4, 0, 0, 0);
    step("prio_l", 0,0,1,1,0, 4'h8, 4'h8, 0, 0, 0);
    step("loadF",  0,0,1,0,0, 4'hF, 4'hF, 0, 0, 0);
    step("callF",  0,1,0,0,0, 4'h6, 4'h6, 1, 0, 0);
    step("retwrap",1,0,0,0,0, 4'h0, 4'h0, 0, 0, 0);

    // Async reset mid-cycle after two calls
    step("call3",  0,1,0,0,0, 4'h3, 4'h3, 1, 0, 0);
    step("call8",  0,1,0,0,0, 4'h8, 4'h8, 2, 0, 0);
    step("ovf_pre",0,0,0,0,0, 4'h0, 4'h8, 2, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    e.pc = 4'h0; e.depth = 0; e.ovf = 0; e.unf = 0;
    compare("async_rst", e);
    @(negedge clk);
    rst_n = 1'b1;
    step("ret_after_rst", 1,0,0,0,0, 4'h0, 4'h0, 0, 0, 1);

    // Bus output gating
    step("inc_b", 0,0,0,1,0, 4'h0, 4'h1, 0, 0, 1);
    bus.out_en = 0;
    #1;
    check("bus_off", 8'(bus.bus_out), 8'h00);
    step("hold_off", 0,0,0,0,0, 4'h0, 4'h1, 0, 0, 1);
    step("inc_off",  0,0,0,1,0, 4'h0, 4'h2, 0, 0, 1);
    bus.out_en = 1;
    #1;
    check("bus_on", 8'(bus.bus_out), 8'h02);

    if (sb.size() != 0) begin
      total++; bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
